// File: rtl/substitution_layer_iter.sv
// Ascon p_S substitution layer, iterative: NB_SBOX columns per cycle.
// Ports: clock_i, reset_i (sync, high), start_i, substitution_i,
//        substitution_o (working/result register), busy_o, done_o (pulse).

package ascon_pkg;
   // Row r of the 5x64 state is s[r]; column i is {s[0][i],...,s[4][i]}.
   typedef logic [4:0][63:0] type_state;
endpackage

// Ascon 5-bit S-box, bit-sliced form.
// x/y: {s0,s1,s2,s3,s4} with s0 in the MSB.
module ascon_sbox (
   input  logic [4:0] x,
   output logic [4:0] y
);
   logic a0, a1, a2, a3, a4;
   logic b0, b1, b2, b3, b4;

   // input whitening
   assign a0 = x[4] ^ x[0];
   assign a1 = x[3];
   assign a2 = x[2] ^ x[3];
   assign a3 = x[1];
   assign a4 = x[0] ^ x[1];

   // chi-like nonlinear step
   assign b0 = a0 ^ (~a1 & a2);
   assign b1 = a1 ^ (~a2 & a3);
   assign b2 = a2 ^ (~a3 & a4);
   assign b3 = a3 ^ (~a4 & a0);
   assign b4 = a4 ^ (~a0 & a1);

   // output mixing and final inversion of row 2
   assign y[4] = b0 ^ b4;
   assign y[3] = b1 ^ b0;
   assign y[2] = ~b2;
   assign y[1] = b3 ^ b2;
   assign y[0] = b4;
endmodule

module substitution_layer_iter
   import ascon_pkg::*;
#(
   parameter int NB_SBOX = 8
) (
   input  logic      clock_i,
   input  logic      reset_i,
   input  logic      start_i,
   input  type_state substitution_i,
   output type_state substitution_o,
   output logic      busy_o,
   output logic      done_o
);
   localparam int N_SLICE = 64 / NB_SBOX;
   localparam int CNT_W = (N_SLICE > 1) ? $clog2(N_SLICE) : 1;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t                       state_q;
   state_t                       state_d;
   logic [CNT_W-1:0]             cnt_q;
   logic [CNT_W-1:0]             cnt_d;
   logic                         load;
   logic                         sub_en;
   logic                         last;
   logic [6:0]                   base;
   type_state                    st_q;
   type_state                    st_d;
   logic [4:0][NB_SBOX-1:0]      slice_in;
   logic [4:0][NB_SBOX-1:0]      slice_out;
   logic [NB_SBOX-1:0][4:0]      sbox_x;
   logic [NB_SBOX-1:0][4:0]      sbox_y;

   assign last = (cnt_q == CNT_W'(N_SLICE - 1));
   assign base = 7'(cnt_q) * 7'(NB_SBOX);

   // Column mux: pick the current slice of every row.
   always_comb begin
      slice_in = '0;
      for (int r = 0; r < 5; r++) begin
         slice_in[r] = st_q[r][base +: NB_SBOX];
      end
   end

   // Regroup row slices into per-column S-box words (row 0 is MSB).
   always_comb begin
      sbox_x = '0;
      for (int j = 0; j < NB_SBOX; j++) begin
         for (int r = 0; r < 5; r++) begin
            sbox_x[j][4-r] = slice_in[r][j];
         end
      end
   end

   for (genvar j = 0; j < NB_SBOX; j++) begin : g_sbox
      ascon_sbox u_sbox (
         .x (sbox_x[j]),
         .y (sbox_y[j])
      );
   end

   always_comb begin
      slice_out = '0;
      for (int j = 0; j < NB_SBOX; j++) begin
         for (int r = 0; r < 5; r++) begin
            slice_out[r][j] = sbox_y[j][4-r];
         end
      end
   end

   // Next working register: load on start, in-place slice update in BUSY.
   always_comb begin
      st_d = st_q;
      if (load) begin
         st_d = substitution_i;
      end else if (sub_en) begin
         for (int r = 0; r < 5; r++) begin
            st_d[r][base +: NB_SBOX] = slice_out[r];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      sub_en  = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               load    = 1'b1;
               cnt_d   = '0;
               state_d = BUSY;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            sub_en = 1'b1;
            if (last) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         st_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         st_q    <= st_d;
      end
   end

   assign substitution_o = st_q;
   assign busy_o         = (state_q == BUSY);
   assign done_o         = (state_q == DONE);
endmodule

// File: tb/tb_substitution_layer_iter.sv
// Bench for substitution_layer_iter at NB_SBOX = 8, 1, 4, 64.
// Drivers queue expected results; monitors check them on done_o.

module tb_substitution_layer_iter;
   import ascon_pkg::*;

   localparam int NV = 22;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] A = 64'hAAAA_AAAA_AAAA_AAAA;
   localparam logic [63:0] L = 64'h0000_0000_FFFF_FFFF;
   localparam logic [63:0] P = 64'h0123_4567_89AB_CDEF;

   logic        clk = 1'b0;
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   bit          go = 1'b0;
   type_state   vec [NV];
   type_state   expv [NV];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm,
                      input logic [319:0] act,
                      input logic [319:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   function automatic type_state mk(input logic [63:0] r0, r1, r2, r3, r4);
      type_state s;
      s[0] = r0;
      s[1] = r1;
      s[2] = r2;
      s[3] = r3;
      s[4] = r4;
      return s;
   endfunction

   function automatic logic [4:0] sbox_ref(input logic [4:0] v);
      logic [4:0] o;
      case (v)
         5'd0:  o = 5'h04;  5'd1:  o = 5'h0b;
         5'd2:  o = 5'h1f;  5'd3:  o = 5'h14;
         5'd4:  o = 5'h1a;  5'd5:  o = 5'h15;
         5'd6:  o = 5'h09;  5'd7:  o = 5'h02;
         5'd8:  o = 5'h1b;  5'd9:  o = 5'h05;
         5'd10: o = 5'h08;  5'd11: o = 5'h12;
         5'd12: o = 5'h1d;  5'd13: o = 5'h03;
         5'd14: o = 5'h06;  5'd15: o = 5'h1c;
         5'd16: o = 5'h1e;  5'd17: o = 5'h13;
         5'd18: o = 5'h07;  5'd19: o = 5'h0e;
         5'd20: o = 5'h00;  5'd21: o = 5'h0d;
         5'd22: o = 5'h11;  5'd23: o = 5'h18;
         5'd24: o = 5'h10;  5'd25: o = 5'h0c;
         5'd26: o = 5'h01;  5'd27: o = 5'h19;
         5'd28: o = 5'h16;  5'd29: o = 5'h0a;
         5'd30: o = 5'h0f;  default: o = 5'h17;
      endcase
      return o;
   endfunction

   function automatic type_state layer_ref(input type_state s);
      type_state  o;
      logic [4:0] c;
      logic [4:0] y;
      o = '0;
      for (int i = 0; i < 64; i++) begin
         c = {s[0][i], s[1][i], s[2][i], s[3][i], s[4][i]};
         y = sbox_ref(c);
         for (int r = 0; r < 5; r++) o[r][i] = y[4-r];
      end
      return o;
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int NB = (g == 0) ? 8 : (g == 1) ? 1 :
                          (g == 2) ? 4 : 64;
      localparam int NS = 64 / NB;

      logic        rst;
      logic        start;
      logic        busy;
      logic        done;
      type_state   din;
      type_state   dout;
      type_state   q_res [$];
      int unsigned q_cyc [$];
      type_state   m_res;
      int unsigned m_cyc;
      bit          fin = 1'b0;

      substitution_layer_iter #(.NB_SBOX(NB)) dut (
         .clock_i        (clk),
         .reset_i        (rst),
         .start_i        (start),
         .substitution_i (din),
         .substitution_o (dout),
         .busy_o         (busy),
         .done_o         (done)
      );

      always @(negedge clk) begin
         if (done === 1'b1) begin
            if (q_res.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_done nb%0d act=1 exp=0", NB);
            end else begin
               m_res = q_res.pop_front();
               m_cyc = q_cyc.pop_front();
               chk($sformatf("result nb%0d", NB), dout, m_res);
               chk($sformatf("latency nb%0d", NB),
                   320'(cyc), 320'(m_cyc));
               chk($sformatf("busy_at_done nb%0d", NB),
                   320'(busy), 320'(0));
            end
         end
      end

      // pk: counter value during which start_i is re-pulsed (ignored).
      // rk: counter value during which reset_i aborts the layer.
      task automatic run(input type_state d, input type_state e,
                         input int pk, input int rk,
                         input type_state pd);
         int t;
         start = 1'b1;
         din = d;
         if (rk < 0) begin
            q_res.push_back(e);
            q_cyc.push_back(cyc + 1 + NS);
         end
         for (int k = 0; k < NS; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 0)
               chk($sformatf("busy nb%0d", NB),
                   320'(busy), 320'(1));
            if (k == pk) begin
               start = 1'b1;
               din = pd;
            end
            if (k == rk) begin
               rst = 1'b1;
               break;
            end
         end
         @(negedge clk);
         start = 1'b0;
         if (rk >= 0) begin
            rst = 1'b0;
            chk($sformatf("abort_out nb%0d", NB), dout, '0);
            chk($sformatf("abort_busy nb%0d", NB),
                320'(busy), 320'(0));
            chk($sformatf("abort_done nb%0d", NB),
                320'(done), 320'(0));
            repeat (NS + 3) @(negedge clk);
         end else begin
            t = 0;
            while (done !== 1'b1 && t < 200) begin
               @(negedge clk);
               t++;
            end
            if (done !== 1'b1) begin
               checks++;
               errors++;
               $display("FAIL done_timeout nb%0d act=0 exp=1", NB);
            end
         end
      endtask

      initial begin
         rst = 1'b1;
         start = 1'b1;
         din = '1;
         wait (go);
         repeat (2) @(posedge clk);
         @(negedge clk);
         chk($sformatf("reset_out nb%0d", NB), dout, '0);
         chk($sformatf("reset_busy nb%0d", NB),
             320'(busy), 320'(0));
         chk($sformatf("reset_done nb%0d", NB),
             320'(done), 320'(0));
         rst = 1'b0;
         start = 1'b0;
         @(negedge clk);
         for (int i = 0; i < NV; i++)
            run(vec[i], expv[i], -1, -1, '0);
         run(vec[4], expv[4], (NS > 3) ? 3 : NS - 1, -1, vec[1]);
         run(vec[2], '0, -1, (NS > 5) ? 5 : NS - 1, '0);
         run(vec[3], expv[3], -1, -1, '0);
         repeat (4) @(negedge clk);
         chk($sformatf("drain nb%0d", NB),
             320'(q_res.size()), 320'(0));
         fin = 1'b1;
      end
   end

   initial begin
      bit all_fin;
      vec[0]  = mk(0, 0, 0, 0, 0);
      expv[0] = mk(0, 0, ONES, 0, 0);
      vec[1]  = mk(ONES, ONES, ONES, ONES, ONES);
      expv[1] = mk(ONES, 0, ONES, ONES, ONES);
      vec[2]  = mk(A, 0, 0, 0, 0);
      expv[2] = mk(A, A, ONES, A, 0);
      vec[3]  = mk(L, 0, 0, 0, 0);
      expv[3] = mk(L, L, ONES, L, 0);
      vec[4]  = mk(0, 0, 0, 0, P);
      expv[4] = mk(0, P, ~P, P, P);
      vec[5]  = mk(0, 0, ONES, 0, ONES);
      expv[5] = mk(ONES, 0, ONES, 0, ONES);
      for (int i = 6; i < NV; i++) begin
         for (int r = 0; r < 5; r++)
            vec[i][r] = {$urandom(), $urandom()};
         expv[i] = layer_ref(vec[i]);
      end
      go = 1'b1;
      all_fin = 1'b0;
      for (int t = 0; t < 40000 && !all_fin; t++) begin
         @(negedge clk);
         all_fin = g_dut[0].fin && g_dut[1].fin &&
                   g_dut[2].fin && g_dut[3].fin;
      end
      if (!all_fin) begin
         checks++;
         errors++;
         $display("FAIL watchdog act=running exp=finished");
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
